// File: rtl/b_responder.sv
// AXI4 slave write-response generator: pairs queued AW IDs with completed W responses in order.
// Optional handshake/error counters are enabled with B_RESPONDER_STATS_EN.
module b_responder #(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                aw_push,
  input  logic [ID_WIDTH-1:0] aw_id,
  output logic                aw_full,
  input  logic                w_push,
  input  logic [1:0]          w_resp,
  output logic                w_full,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                idle
`ifdef B_RESPONDER_STATS_EN
  ,
  output logic [15:0]         resp_count,
  output logic [15:0]         err_count
`endif
);

  localparam int              PW      = $clog2(DEPTH);
  localparam logic [PW:0]     CNT_MAX = (PW+1)'(DEPTH);
  localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  logic [ID_WIDTH-1:0] r_aw_mem [DEPTH];
  logic [PW-1:0]       r_aw_wp, r_aw_rp;
  logic [PW:0]         r_aw_cnt;

  logic [1:0]          r_w_mem [DEPTH];
  logic [PW-1:0]       r_w_wp, r_w_rp;
  logic [PW:0]         r_w_cnt;

  logic                r_bvalid;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]          r_bresp;

  logic w_aw_push_ok, w_w_push_ok, w_pop;

  assign aw_full = (r_aw_cnt == CNT_MAX);
  assign w_full  = (r_w_cnt == CNT_MAX);

  // Pushes into a full FIFO are silently dropped; full comes from registered occupancy.
  assign w_aw_push_ok = aw_push && !aw_full;
  assign w_w_push_ok  = w_push && !w_full;
  assign w_pop        = (r_aw_cnt != '0) && (r_w_cnt != '0) && (!r_bvalid || bready);

  assign bvalid = r_bvalid;
  assign bid    = r_bid;
  assign bresp  = r_bresp;
  assign idle   = (r_aw_cnt == '0) && (r_w_cnt == '0) && !r_bvalid;

  always_ff @(posedge clk) begin
    if (w_aw_push_ok) r_aw_mem[r_aw_wp] <= aw_id;
    if (w_w_push_ok)  r_w_mem[r_w_wp]   <= w_resp;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_wp  <= '0;
      r_aw_rp  <= '0;
      r_aw_cnt <= '0;
    end else begin
      if (w_aw_push_ok) r_aw_wp <= r_aw_wp + PTR_ONE;
      if (w_pop)        r_aw_rp <= r_aw_rp + PTR_ONE;
      case ({w_aw_push_ok, w_pop})
        2'b10:   r_aw_cnt <= r_aw_cnt + CNT_ONE;
        2'b01:   r_aw_cnt <= r_aw_cnt - CNT_ONE;
        default: r_aw_cnt <= r_aw_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_w_wp  <= '0;
      r_w_rp  <= '0;
      r_w_cnt <= '0;
    end else begin
      if (w_w_push_ok) r_w_wp <= r_w_wp + PTR_ONE;
      if (w_pop)       r_w_rp <= r_w_rp + PTR_ONE;
      case ({w_w_push_ok, w_pop})
        2'b10:   r_w_cnt <= r_w_cnt + CNT_ONE;
        2'b01:   r_w_cnt <= r_w_cnt - CNT_ONE;
        default: r_w_cnt <= r_w_cnt;
      endcase
    end
  end

  // Output register: the valid flag is the only control state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= '0;
    end else if (w_pop) begin
      r_bvalid <= 1'b1;
      r_bid    <= r_aw_mem[r_aw_rp];
      r_bresp  <= r_w_mem[r_w_rp];
    end else if (r_bvalid && bready) begin
      r_bvalid <= 1'b0;
    end
  end

`ifdef B_RESPONDER_STATS_EN
  logic [15:0] r_resp_cnt, r_err_cnt;
  logic        w_hs;

  assign w_hs       = r_bvalid && bready;
  assign resp_count = r_resp_cnt;
  assign err_count  = r_err_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_hs) begin
      if (r_resp_cnt != 16'hFFFF)             r_resp_cnt <= r_resp_cnt + 16'd1;
      if (r_bresp[1] && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn) begin
      assert (!(aw_push && aw_full)) else $warning("b_responder: aw_push while aw_full, push dropped");
      assert (!(w_push && w_full))   else $warning("b_responder: w_push while w_full, push dropped");
    end
  end
`endif

endmodule

// File: tb/tb_b_responder.sv
// Directed bench for b_responder: pairing, ordering, full/drop, backpressure, reset, optional stats.
module tb_b_responder;
  logic       clk = 1'b0;
  logic       rstn;
  logic       aw_push;
  logic [3:0] aw_id;
  logic       aw_full;
  logic       w_push;
  logic [1:0] w_resp;
  logic       w_full;
  logic       bvalid;
  logic       bready;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic       idle;
`ifdef B_RESPONDER_STATS_EN
  logic [15:0] resp_count, err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  b_responder #(.ID_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .aw_push(aw_push), .aw_id(aw_id), .aw_full(aw_full),
    .w_push(w_push), .w_resp(w_resp), .w_full(w_full),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .idle(idle)
`ifdef B_RESPONDER_STATS_EN
    , .resp_count(resp_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; aw_push = 0; aw_id = 0; w_push = 0; w_resp = 0; bready = 0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bvalid, bid, bresp, aw_full, w_full, idle} !== {1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got bvalid=%b bid=%0d bresp=%0d awf=%b wf=%b idle=%b, want 0 0 0 0 0 1",
               bvalid, bid, bresp, aw_full, w_full, idle);
    end
  endtask

  task automatic test_single_pair();
    bready = 1;
    aw_push = 1; aw_id = 3; step();
    aw_push = 0; w_push = 1; w_resp = 2'b00; step();
    w_push = 0;
    n_checks++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL single_early: bvalid=%b want 0", bvalid); end
    step();
    n_checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd3, 2'b00}) begin
      n_fail++; $display("FAIL single_b: got %b/%0d/%0d want 1/3/0", bvalid, bid, bresp);
    end
    step();
    n_checks++;
    if ({bvalid, idle} !== 2'b01) begin
      n_fail++; $display("FAIL single_done: bvalid=%b idle=%b want 0 1", bvalid, idle);
    end
  endtask

  task automatic test_w_before_aw();
    int beats = 0;
    bready = 0;
    w_push = 1; w_resp = 2'b10; step();
    w_push = 0;
    step(); step(); step();
    n_checks++;
    if ({bvalid, idle} !== 2'b00) begin
      n_fail++; $display("FAIL wfirst_wait: bvalid=%b idle=%b want 0 0", bvalid, idle);
    end
    aw_push = 1; aw_id = 7; step();
    aw_push = 0;
    step();
    n_checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd7, 2'b10}) begin
      n_fail++; $display("FAIL wfirst_b: got %b/%0d/%0d want 1/7/2", bvalid, bid, bresp);
    end
    bready = 1;
    for (int i = 0; i < 6; i++) begin
      if (bvalid) beats++;
      step();
    end
    n_checks++;
    if (beats !== 1) begin n_fail++; $display("FAIL wfirst_once: beats=%0d want 1", beats); end
  endtask

  task automatic test_fill_aw();
    logic [3:0] seen [$];
    bready = 0;
    for (int i = 0; i < 4; i++) begin
      aw_push = 1; aw_id = 4'(i); step();
    end
    aw_push = 0;
    n_checks++;
    if (aw_full !== 1'b1) begin n_fail++; $display("FAIL aw_full_set: aw_full=%b want 1", aw_full); end
    aw_push = 1; aw_id = 9; step();
    aw_push = 0;
    n_checks++;
    if ({aw_full, bvalid} !== 2'b10) begin
      n_fail++; $display("FAIL aw_drop: aw_full=%b bvalid=%b want 1 0", aw_full, bvalid);
    end
    bready = 1;
    for (int i = 0; i < 12; i++) begin
      w_push = (i < 4); w_resp = 2'b00;
      step();
      if (bvalid) seen.push_back(bid);
    end
    w_push = 0;
    n_checks++;
    if (seen.size() !== 4) begin
      n_fail++; $display("FAIL aw_fill_count: beats=%0d want 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seen[i] !== 4'(i)) begin n_fail++; $display("FAIL aw_fill_order[%0d]: bid=%0d want %0d", i, seen[i], i); end
      end
    end
    n_checks++;
    if ({aw_full, idle} !== 2'b01) begin
      n_fail++; $display("FAIL aw_fill_end: aw_full=%b idle=%b want 0 1", aw_full, idle);
    end
  endtask

  task automatic test_fill_w();
    logic [1:0] rsp [4];
    logic [5:0] seen [$];
    rsp[0] = 2'b11; rsp[1] = 2'b00; rsp[2] = 2'b10; rsp[3] = 2'b01;
    bready = 1;
    for (int i = 0; i < 4; i++) begin
      w_push = 1; w_resp = rsp[i]; step();
    end
    w_push = 0;
    n_checks++;
    if ({w_full, bvalid} !== 2'b10) begin
      n_fail++; $display("FAIL w_full_set: w_full=%b bvalid=%b want 1 0", w_full, bvalid);
    end
    for (int i = 0; i < 10; i++) begin
      aw_push = (i < 4); aw_id = 4'(8 + i);
      step();
      if (bvalid) seen.push_back({bid, bresp});
    end
    aw_push = 0;
    n_checks++;
    if (seen.size() !== 4) begin
      n_fail++; $display("FAIL w_fill_count: beats=%0d want 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seen[i] !== {4'(8 + i), rsp[i]}) begin
          n_fail++; $display("FAIL w_fill_beat[%0d]: got id=%0d resp=%0d want id=%0d resp=%0d",
                             i, seen[i][5:2], seen[i][1:0], 8 + i, rsp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bready = 0;
    aw_push = 1; aw_id = 5; w_push = 1; w_resp = 2'b10; step();
    aw_id = 6; w_resp = 2'b11; step();
    aw_push = 0; w_push = 0;
    n_checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd5, 2'b10}) begin
      n_fail++; $display("FAIL bp_first: got %b/%0d/%0d want 1/5/2", bvalid, bid, bresp);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if ({bvalid, bid, bresp} !== {1'b1, 4'd5, 2'b10}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: unstable cycles=%0d want 0", bad); end
    bready = 1;
    step();
    n_checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd6, 2'b11}) begin
      n_fail++; $display("FAIL bp_second: got %b/%0d/%0d want 1/6/3", bvalid, bid, bresp);
    end
    step();
    n_checks++;
    if ({bvalid, idle} !== 2'b01) begin
      n_fail++; $display("FAIL bp_drain: bvalid=%b idle=%b want 0 1", bvalid, idle);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    bready = 0;
    aw_push = 1; aw_id = 1; w_push = 1; w_resp = 2'b10; step();
    aw_id = 2; w_resp = 2'b00; step();
    aw_push = 0; w_push = 0;
    step();
    n_checks++;
    if (bvalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: bvalid=%b want 1", bvalid); end
    rstn = 0;
    #1;
    n_checks++;
    if ({bvalid, aw_full, w_full, idle} !== 4'b0001) begin
      n_fail++; $display("FAIL rst_async: bvalid=%b awf=%b wf=%b idle=%b want 0 0 0 1", bvalid, aw_full, w_full, idle);
    end
    step();
    rstn = 1;
    bready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bvalid || !idle) beats++;
    end
    n_checks++;
    if (beats !== 0) begin n_fail++; $display("FAIL rst_after: busy cycles=%0d want 0", beats); end
    aw_push = 1; aw_id = 4; w_push = 1; w_resp = 2'b01; step();
    aw_push = 0; w_push = 0;
    step();
    n_checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd4, 2'b01}) begin
      n_fail++; $display("FAIL exokay_pass: got %b/%0d/%0d want 1/4/1", bvalid, bid, bresp);
    end
    step();
  endtask

`ifdef B_RESPONDER_STATS_EN
  task automatic test_stats();
    logic [1:0] rsp [5];
    rsp[0] = 2'b00; rsp[1] = 2'b11; rsp[2] = 2'b00; rsp[3] = 2'b11; rsp[4] = 2'b00;
    do_reset();
    bready = 1;
    for (int i = 0; i < 5; i++) begin
      aw_push = 1; aw_id = 4'(i); w_push = 1; w_resp = rsp[i]; step();
    end
    aw_push = 0; w_push = 0;
    step(); step(); step();
    n_checks++;
    if ({resp_count, err_count} !== {16'd5, 16'd2}) begin
      n_fail++; $display("FAIL stats_count: resp=%0d err=%0d want 5 2", resp_count, err_count);
    end
    force dut.r_resp_cnt = 16'hFFFF;
    #1;
    release dut.r_resp_cnt;
    aw_push = 1; aw_id = 1; w_push = 1; w_resp = 2'b00; step();
    aw_push = 0; w_push = 0;
    step(); step(); step();
    n_checks++;
    if (resp_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_sat: resp=%h want ffff", resp_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pair();
    test_w_before_aw();
    test_fill_aw();
    test_fill_w();
    test_backpressure();
    test_reset_mid();
`ifdef B_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/b_responder.md
Name: b_responder

Overview:
- Slave-side AXI4 write-response generator: the responder counterpart of the DMA's B-channel consumer.
- Pairs each accepted AW burst (ID) with its completed W burst (response code) in arrival order.
- Issues exactly one B response per burst, honouring bready backpressure.
- Sits behind the AW/W acceptance logic of on-chip write targets (memory models, CSR slaves) and in the DMA loopback test harness.

Parameters:
- ID_WIDTH, 4, width of AXI ID carried from AW to B.
- DEPTH, 4, entries in each of the AW-ID FIFO and the W-done FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- aw_push  in  1  AW handshake completed this cycle.
- aw_id  in  ID_WIDTH  awid of that burst.
- aw_full  out  1  AW-ID FIFO full; front end must hold awready low.
- w_push  in  1  W beat with wlast handshaken this cycle.
- w_resp  in  2  accumulated response for that burst (00 OKAY, 10 SLVERR, 11 DECERR).
- w_full  out  1  W-done FIFO full; front end must hold wready low on a last beat.
- bvalid  out  1  B channel valid.
- bready  in  1  B channel ready.
- bid  out  ID_WIDTH  B channel ID.
- bresp  out  2  B channel response.
- idle  out  1  both FIFOs empty and no B pending.

Behaviour:
- Reset (async assert, sync deassert to clk):
  - bvalid=0, bid=0, bresp=0.
  - Both FIFO occupancies 0; aw_full=0, w_full=0, idle=1.
  - Reset mid-operation discards all queued and pending responses; no partial B is held.
- FIFOs:
  - Two independent circular FIFOs, DEPTH entries each.
  - Read/write pointers are clog2(DEPTH) bits and wrap naturally.
  - Occupancy counter is clog2(DEPTH)+1 bits.
  - full = (occupancy==DEPTH), driven from registers, not combinational on the push.
- Push rules:
  - aw_push writes aw_id; w_push writes w_resp.
  - A push while full is dropped with no state change. This is a protocol violation; the simulation assertion fires.
  - Push and pop in the same cycle on a non-full FIFO: occupancy unchanged, both take effect.
- Pop/issue:
  - pop = both FIFOs non-empty AND (!bvalid OR bready).
  - On pop, the next edge loads bid/bresp from the FIFO heads and sets bvalid=1.
  - bvalid && bready with no pop: next edge clears bvalid.
- Output stability: while bvalid && !bready, bvalid, bid and bresp stay constant.
- Latency:
  - The later of the AW/W pushes for a pair is sampled at edge t; bvalid rises at edge t+1 (one cycle after the FIFO write).
  - Back-to-back: with bready held high and pairs available, one B per cycle.
- Ordering:
  - Strict FIFO order.
  - W bursts may complete before their AW (W-done FIFO leads) or after (AW FIFO leads); both are legal.
- Response code: bresp is w_resp exactly as pushed; value 01 (EXOKAY) is passed through unmodified.
- idle is a registered-state function: both occupancies 0 and bvalid=0.
- No state machine beyond the output register; the valid/ready flag is the only control state.

Optional Feature:
- Macro B_RESPONDER_STATS_EN.
- When defined, adds two outputs, both reset to 0 and saturating at all-ones (no wrap):
  - resp_count, out, 16: counts B handshakes (bvalid && bready).
  - err_count, out, 16: counts handshakes with bresp[1]==1.
- When undefined, the ports and counters do not exist and the core behaviour is identical.

Test Plan:
- Single pair: aw_push id=3, next cycle w_push resp=00 → bvalid one cycle later with bid=3, bresp=00; bready=1 → bvalid=0 next cycle, idle=1.
- W before AW: w_push resp=10, three cycles idle, aw_push id=7 → bvalid, bid=7, bresp=10, issued exactly once.
- Fill/full: four aw_push (ids 0..3) with no W → aw_full=1 after 4th. A 5th aw_push (id 9) is dropped. Four w_push with bready=1 → B ids 0,1,2,3 in order; id 9 never appears.
- Backpressure: two pairs queued, bready=0 for 5 cycles → bvalid stays high with the first bid/bresp unchanged. bready=1 → two consecutive B beats on consecutive cycles.
- Reset mid-operation: two pairs queued, bvalid=1, rstn low for one cycle → bvalid=0, aw_full=0, w_full=0, idle=1 immediately. No B issued after release until new pushes.
- B_RESPONDER_STATS_EN: 3 OKAY + 2 DECERR responses handshaken → resp_count=5, err_count=2. Forcing resp_count to 0xFFFF then one more handshake → stays 0xFFFF.
